// File: rtl/palette_arbiter.sv
// Two-player palette lookup arbiter: round-robin grant into a shared combinational
// palette ROM, one-deep registered result with valid/ready and per-player counters.
module palette_arbiter_cnt (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        inc,
   output logic [15:0] count
);
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n)                  count <= '0;
      else if (inc && count != '1)   count <= count + 16'd1;
   end
endmodule

module palette_arbiter #(
   parameter logic [3:0] KEY_INDEX  = 4'd2,
   parameter bit         KEY_ENABLE = 1'b1
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic        p1_req,
   input  logic [3:0]  p1_index,
   output logic        p1_gnt,
   input  logic        p2_req,
   input  logic [3:0]  p2_index,
   output logic        p2_gnt,
   output logic [3:0]  pal_index,
   input  logic [3:0]  pal_red,
   input  logic [3:0]  pal_green,
   input  logic [3:0]  pal_blue,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_owner,
   output logic [3:0]  out_red,
   output logic [3:0]  out_green,
   output logic [3:0]  out_blue,
   output logic        out_transparent,
   output logic [15:0] p1_count,
   output logic [15:0] p2_count
);
   localparam int NUM_REQ = 2;

   logic [NUM_REQ-1:0]       req, gnt;
   logic [NUM_REQ-1:0][3:0]  idx;
   logic [NUM_REQ-1:0][15:0] cnt;
   logic                     last_gnt;   // 0 = P1, 1 = P2
   logic                     free, xfer, win;
   logic [3:0]               win_idx, held_idx;

   assign req  = {p2_req, p1_req};
   assign idx  = {p2_index, p1_index};
   assign free = !out_valid || out_ready;

   // P1 wins unless P2 is also asking and P1 was served last.
   always_comb begin
      gnt = '0;
      if (Reset_n && free) begin
         if (req[0] && (!req[1] || last_gnt)) gnt[0] = 1'b1;
         else if (req[1])                     gnt[1] = 1'b1;
      end
   end

   assign p1_gnt    = gnt[0];
   assign p2_gnt    = gnt[1];
   assign xfer      = |gnt;
   assign win       = gnt[1];
   assign win_idx   = idx[win];
   assign pal_index = xfer ? win_idx : held_idx;

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         out_valid       <= 1'b0;
         out_owner       <= 1'b0;
         out_red         <= '0;
         out_green       <= '0;
         out_blue        <= '0;
         out_transparent <= 1'b0;
         held_idx        <= '0;
         last_gnt        <= 1'b1;
      end else if (xfer) begin
         out_valid       <= 1'b1;
         out_owner       <= win;
         out_red         <= pal_red;
         out_green       <= pal_green;
         out_blue        <= pal_blue;
         out_transparent <= KEY_ENABLE && (win_idx == KEY_INDEX);
         held_idx        <= win_idx;
         last_gnt        <= win;
      end else if (out_ready) begin
         out_valid       <= 1'b0;
      end
   end

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      palette_arbiter_cnt u_cnt (
         .Clk     (Clk),
         .Reset_n (Reset_n),
         .inc     (gnt[i]),
         .count   (cnt[i])
      );
   end

   assign p1_count = cnt[0];
   assign p2_count = cnt[1];
endmodule
